// File: rtl/prog_delay_line.sv
// Programmable delay line: data_out follows data_in by D accepted writes (D=1..MAX_DELAY).
// Latency: one register stage; on write n, data_out carries the sample of write n-D+1.
// Backpressure: none; we=0 freezes buffer, pointer, fill count and outputs.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   we, data_in      write strobe and sample captured on each accepted write
//   delay_load/sel   one-cycle strobe loading a new (clamped) delay
//   data_out         registered delayed sample, forced to 0 until the line has filled
//   out_valid        data_out is a genuine sample at the current delay
//   delay_cur        delay currently in effect
module prog_delay_line #(
  parameter int WIDTH         = 1,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 1,
  localparam int SEL_W        = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] data_in,
  input  logic             delay_load,
  input  logic [SEL_W-1:0] delay_sel,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [SEL_W-1:0] delay_cur
);

  localparam int PTR_W = $clog2(MAX_DELAY);
  // Wide enough to hold wr_ptr + MAX_DELAY without overflow.
  localparam int IDX_W = SEL_W + 1;

  typedef enum logic {ST_FILL, ST_RUN} state_t;

  state_t             state_q,     state_d;
  logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [SEL_W-1:0]   fcnt_q,      fcnt_d;
  logic [SEL_W-1:0]   delay_cur_q, delay_cur_d;
  logic [WIDTH-1:0]   data_out_q,  data_out_d;
  logic               out_valid_q, out_valid_d;

  // Sample storage; never reset, the fill logic keeps stale entries hidden.
  logic [WIDTH-1:0]   buf_mem [MAX_DELAY];

  logic [IDX_W-1:0]   rd_raw;
  logic [IDX_W-1:0]   rd_wrap;
  logic [PTR_W-1:0]   rd_idx;
  logic [WIDTH-1:0]   rd_data;
  logic [SEL_W-1:0]   sel_clamped;
  logic [SEL_W-1:0]   fcnt_inc;
  logic               unused_rd_hi;

  // Read index = (wr_ptr - (D-1)) mod MAX_DELAY. Adding MAX_DELAY first keeps
  // the subtraction non-negative, so a single conditional wrap suffices.
  always_comb begin
    rd_raw  = IDX_W'(wr_ptr_q) + IDX_W'(MAX_DELAY) + IDX_W'(1) - IDX_W'(delay_cur_q);
    rd_wrap = rd_raw;
    if (rd_raw >= IDX_W'(MAX_DELAY)) begin
      rd_wrap = rd_raw - IDX_W'(MAX_DELAY);
    end
  end

  assign rd_idx       = rd_wrap[PTR_W-1:0];
  assign unused_rd_hi = ^rd_wrap[IDX_W-1:PTR_W];

  // D=1 reads the slot being written on this very edge, so bypass the RAM.
  assign rd_data = (delay_cur_q == SEL_W'(1)) ? data_in : buf_mem[rd_idx];

  always_comb begin
    sel_clamped = delay_sel;
    if (delay_sel == '0) begin
      sel_clamped = SEL_W'(1);
    end else if (delay_sel > SEL_W'(MAX_DELAY)) begin
      sel_clamped = SEL_W'(MAX_DELAY);
    end
  end

  assign fcnt_inc = fcnt_q + SEL_W'(1);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fcnt_d      = fcnt_q;
    delay_cur_d = delay_cur_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;

    if (we) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_DELAY - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    if (delay_load) begin
      // New delay restarts the fill; a write on the same edge is the first fill write.
      delay_cur_d = sel_clamped;
      state_d     = ST_FILL;
      fcnt_d      = '0;
      data_out_d  = '0;
      out_valid_d = 1'b0;
      if (we) begin
        fcnt_d = SEL_W'(1);
        if (sel_clamped == SEL_W'(1)) begin
          state_d     = ST_RUN;
          data_out_d  = data_in;
          out_valid_d = 1'b1;
        end
      end
    end else if (we) begin
      unique case (state_q)
        ST_FILL: begin
          if (fcnt_inc >= delay_cur_q) begin
            state_d     = ST_RUN;
            fcnt_d      = delay_cur_q;
            data_out_d  = rd_data;
            out_valid_d = 1'b1;
          end else begin
            fcnt_d      = fcnt_inc;
            data_out_d  = '0;
            out_valid_d = 1'b0;
          end
        end
        ST_RUN: begin
          data_out_d  = rd_data;
          out_valid_d = 1'b1;
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      wr_ptr_q    <= '0;
      fcnt_q      <= '0;
      delay_cur_q <= SEL_W'(DEFAULT_DELAY);
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fcnt_q      <= fcnt_d;
      delay_cur_q <= delay_cur_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) begin
      buf_mem[wr_ptr_q] <= data_in;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign delay_cur = delay_cur_q;

endmodule
